adc_fnd_display: RTL and testbench

ADC_FND_DISPLAY -- requirements
Module: adc_fnd_display

---
 rtl/adc_fnd_display.sv | 151 +++++++++++++++
 tb/tb_adc_fnd_display.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adc_fnd_display.sv
// ADC sample display block: 4-sample moving average and a decaying peak hold.
// The selected value is shown on two 7-segment hex digits.
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   adc_data, adc_valid - ADC sample and its single-cycle strobe
//   mode                - 0 shows the moving average, 1 shows the peak
//   clr_peak            - clears the peak register
//   disp_value          - value currently shown (registered)
//   avg_valid           - high once four samples have been accumulated
//   led                 - toggles on every accepted sample
//   fnd_out1, fnd_out2  - active-low {g,f,e,d,c,b,a} codes for the high and low nibble
module adc_fnd_display #(
  parameter int unsigned PEAK_HOLD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic       mode,
  input  logic       clr_peak,
  output logic [7:0] disp_value,
  output logic       avg_valid,
  output logic       led,
  output logic [6:0] fnd_out1,
  output logic [6:0] fnd_out2
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned HOLD_W = (PEAK_HOLD > 2) ? $clog2(PEAK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(PEAK_HOLD - 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] samples [4];
  logic [1:0]        wr_ptr;
  logic [2:0]        fill_cnt;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] peak;
  logic [HOLD_W-1:0] hold_cnt;

  logic [DATA_W-1:0] avg_c;
  logic [SUM_W-1:0]  sum_next_c;

  // Truncated average; unfilled entries are zero, so FILL shows partial averages
  assign avg_c = sum[SUM_W-1:2];
  // The evicted entry is always part of sum, so the subtraction cannot underflow
  assign sum_next_c = sum + SUM_W'(adc_data) - SUM_W'(samples[wr_ptr]);

  // Hex digit to active-low segment code
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_ZERO;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_ZERO;
    endcase
    return seg;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next state: leave FILL on the fourth accepted sample, stay in RUN
  always_comb begin
    state_next = state;
    case (state)
      FILL: if (adc_valid && fill_cnt == 3'd3) state_next = RUN;
      RUN:  state_next = RUN;
      default: state_next = FILL;
    endcase
  end

  // Sample buffer, running sum, fill count, led and avg_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) samples[i] <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      sum       <= '0;
      led       <= 1'b0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= (state_next == RUN);
      if (adc_valid) begin
        samples[wr_ptr] <= adc_data;
        wr_ptr          <= wr_ptr + 2'd1;
        sum             <= sum_next_c;
        led             <= ~led;
        if (state == FILL) fill_cnt <= fill_cnt + 3'd1;
      end
    end
  end

  // Peak hold: clear/new peak reload the hold timer; expiry decays to the average
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak     <= '0;
      hold_cnt <= HOLD_RELOAD;
    end else if (clr_peak) begin
      peak     <= adc_valid ? adc_data : '0;
      hold_cnt <= HOLD_RELOAD;
    end else if (adc_valid && adc_data > peak) begin
      peak     <= adc_data;
      hold_cnt <= HOLD_RELOAD;
    end else if (hold_cnt == '0) begin
      peak     <= avg_c;
      hold_cnt <= HOLD_RELOAD;
    end else begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  // Display value one edge after sum/peak, segment codes one edge after that
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_value <= '0;
      fnd_out1   <= SEG_ZERO;
      fnd_out2   <= SEG_ZERO;
    end else begin
      disp_value <= mode ? peak : avg_c;
      fnd_out1   <= hex_to_seg(disp_value[7:4]);
      fnd_out2   <= hex_to_seg(disp_value[3:0]);
    end
  end

endmodule

// File: tb/tb_adc_fnd_display.sv
// Directed bench for adc_fnd_display: expectations are queued as stimulus is
// driven and popped when the corresponding output is due.
module tb_adc_fnd_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       mode;
  logic       clr_peak;
  logic [7:0] disp_value;
  logic       avg_valid;
  logic       led;
  logic [6:0] fnd_out1;
  logic [6:0] fnd_out2;

  int checks = 0;
  int errors = 0;

  typedef enum int {SEL_DISP, SEL_AVG, SEL_LED, SEL_F1, SEL_F2} sel_t;
  typedef struct {
    string      tag;
    sel_t       sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  adc_fnd_display #(.PEAK_HOLD(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .mode       (mode),
    .clr_peak   (clr_peak),
    .disp_value (disp_value),
    .avg_valid  (avg_valid),
    .led        (led),
    .fnd_out1   (fnd_out1),
    .fnd_out2   (fnd_out2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input sel_t sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare against the live DUT outputs
  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_DISP: obs = disp_value;
        SEL_AVG:  obs = {7'd0, avg_valid};
        SEL_LED:  obs = {7'd0, led};
        SEL_F1:   obs = {1'b0, fnd_out1};
        default:  obs = {1'b0, fnd_out2};
      endcase
      checks++;
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic sample(input logic [7:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic push_reset_state(input string tag);
    push({tag, "_disp"}, SEL_DISP, 8'h00);
    push({tag, "_avg"},  SEL_AVG,  8'h00);
    push({tag, "_led"},  SEL_LED,  8'h00);
    push({tag, "_f1"},   SEL_F1,   8'b01000000);
    push({tag, "_f2"},   SEL_F2,   8'b01000000);
  endtask

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; mode = 1'b0; clr_peak = 1'b0;
    tick();
    push_reset_state("reset");
    drain();
    rst = 1'b0;

    // Averaging stream 0x93 0x15 0xB4 0x10 with adc_valid held high
    adc_valid = 1'b1;
    adc_data = 8'h93; tick();
    adc_data = 8'h15; tick();
    adc_data = 8'hB4; tick();
    push("fill_avg_low", SEL_AVG, 8'h00);
    drain();
    adc_data = 8'h10; tick();
    adc_valid = 1'b0;
    push("avg_valid_rise", SEL_AVG, 8'h01);
    drain();
    push("avg_disp", SEL_DISP, 8'h5B);
    push("avg_f1", SEL_F1, 8'b00010010);
    push("avg_f2", SEL_F2, 8'b00000011);
    tick(); tick();
    drain();

    // Peak display, then decay to the average once the hold expires
    mode = 1'b1;
    push("peak_disp", SEL_DISP, 8'hB4);
    tick();
    drain();
    push("peak_held", SEL_DISP, 8'hB4);
    tick(); tick();
    drain();
    push("peak_decay", SEL_DISP, 8'h5B);
    tick(); tick(); tick(); tick();
    drain();

    // Fifth sample evicts 0x93: sum 249, average 0x3E
    mode = 1'b0;
    sample(8'h20);
    push("wrap_disp", SEL_DISP, 8'h3E);
    tick();
    drain();
    push("wrap_f1", SEL_F1, 8'b00110000);
    push("wrap_f2", SEL_F2, 8'b00000110);
    tick();
    drain();

    // clr_peak with a sample loads the sample; clr_peak alone zeroes peak
    mode = 1'b1;
    clr_peak = 1'b1;
    sample(8'h07);
    clr_peak = 1'b0;
    push("clr_with_sample", SEL_DISP, 8'h07);
    tick();
    drain();
    clr_peak = 1'b1;
    tick();
    clr_peak = 1'b0;
    push("clr_alone", SEL_DISP, 8'h00);
    tick();
    drain();

    // Asynchronous reset mid-run, checked before any clock edge
    #2;
    rst = 1'b1;
    #1;
    push_reset_state("async_reset");
    drain();
    tick(); tick();
    rst = 1'b0;
    mode = 1'b0;

    // Single 0x80 during FILL shows a zero-filled partial average
    sample(8'h80);
    push("partial_disp", SEL_DISP, 8'h20);
    push("partial_avg", SEL_AVG, 8'h00);
    push("partial_led", SEL_LED, 8'h01);
    tick();
    drain();
    push("partial_f1", SEL_F1, 8'b00100100);
    push("partial_f2", SEL_F2, 8'b01000000);
    tick();
    drain();

    // Four more strobes: five total toggles leave led high
    for (int i = 0; i < 4; i++) sample(8'h01);
    push("led_five", SEL_LED, 8'h01);
    push("led_avg_valid", SEL_AVG, 8'h01);
    tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
